// File: rtl/uart_cmd_ctrl_if.sv
// Byte-stream and command handshake bundle for the UART command controller.
// The slave side is the controller itself; the master side is whatever
// feeds it received bytes and consumes the decoded commands.
interface uart_cmd_ctrl_if;
  logic       iRxDV;
  logic [7:0] iRxByte;
  logic [2:0] oCmd;
  logic [7:0] oArg;
  logic       oCmdValid;
  logic       iCmdReady;
  logic       oBusy;
  logic       oErr;
  logic [1:0] oErrCode;

  modport slave (
    input  iRxDV,
    input  iRxByte,
    input  iCmdReady,
    output oCmd,
    output oArg,
    output oCmdValid,
    output oBusy,
    output oErr,
    output oErrCode
  );

  modport master (
    output iRxDV,
    output iRxByte,
    output iCmdReady,
    input  oCmd,
    input  oArg,
    input  oCmdValid,
    input  oBusy,
    input  oErr,
    input  oErrCode
  );
endinterface

// File: rtl/uart_cmd_ctrl.sv
// Frame decoder and command sequencer sitting behind uart_rx.
// Hunts for a sync byte, collects CMD/ARG/CHK, validates the frame and
// offers one command at a time through a valid/ready handshake. An
// inter-byte timeout abandons stalled frames; every error is reported as
// a one-cycle pulse with a cause code that is held until the next error.
module uart_cmd_ctrl #(
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
  parameter int unsigned TIMEOUT_CLKS = 50000
) (
  input  logic            clk,
  input  logic            rst_n,
  uart_cmd_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE,
    GET_CMD,
    GET_ARG,
    GET_CHK,
    ISSUE
  } state_e;

  localparam logic [1:0] ERR_CHECKSUM = 2'd0;
  localparam logic [1:0] ERR_OPCODE   = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
  localparam logic [1:0] ERR_OVERRUN  = 2'd3;

  // The error fires on the edge at which the counter would reach
  // TIMEOUT_CLKS-1, so the comparison is made against the value one below.
  localparam logic [19:0] TIMEOUT_LAST = 20'(TIMEOUT_CLKS - 2);

  state_e      state_q;
  logic [19:0] timeoutCnt_q;
  logic [2:0]  cmdBits_q;
  logic [7:0]  argByte_q;
  logic [2:0]  cmd_q;
  logic [7:0]  arg_q;
  logic        cmdValid_q;
  logic        busy_q;
  logic        err_q;
  logic [1:0]  errCode_q;

  logic [7:0]  frameSum;
  logic        badOpcode;

  // Opcode bytes reaching GET_ARG always have [7:3] clear, so only the low
  // three bits are stored and the checksum zero-extends them.
  assign frameSum  = {5'b0, cmdBits_q} + argByte_q;
  assign badOpcode = (bus.iRxByte[7:3] != 5'b0);

  // Frame sequencer: state, timeout counter, frame buffer and all outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      timeoutCnt_q <= '0;
      cmdBits_q    <= '0;
      argByte_q    <= '0;
      cmd_q        <= '0;
      arg_q        <= '0;
      cmdValid_q   <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      errCode_q    <= '0;
    end else begin
      err_q <= 1'b0;

      case (state_q)
        IDLE: begin
          timeoutCnt_q <= '0;
          if (bus.iRxDV && (bus.iRxByte == SYNC_BYTE)) begin
            state_q <= GET_CMD;
            busy_q  <= 1'b1;
          end
        end

        GET_CMD, GET_ARG, GET_CHK: begin
          if (bus.iRxDV) begin
            timeoutCnt_q <= '0;
            case (state_q)
              GET_CMD: begin
                if (badOpcode) begin
                  err_q     <= 1'b1;
                  errCode_q <= ERR_OPCODE;
                  state_q   <= IDLE;
                  busy_q    <= 1'b0;
                end else begin
                  cmdBits_q <= bus.iRxByte[2:0];
                  state_q   <= GET_ARG;
                end
              end
              GET_ARG: begin
                argByte_q <= bus.iRxByte;
                state_q   <= GET_CHK;
              end
              GET_CHK: begin
                if (bus.iRxByte == frameSum) begin
                  cmd_q      <= cmdBits_q;
                  arg_q      <= argByte_q;
                  cmdValid_q <= 1'b1;
                  state_q    <= ISSUE;
                end else begin
                  err_q     <= 1'b1;
                  errCode_q <= ERR_CHECKSUM;
                  state_q   <= IDLE;
                  busy_q    <= 1'b0;
                end
              end
              default: begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end
            endcase
          end else if (timeoutCnt_q == TIMEOUT_LAST) begin
            timeoutCnt_q <= '0;
            err_q        <= 1'b1;
            errCode_q    <= ERR_TIMEOUT;
            state_q      <= IDLE;
            busy_q       <= 1'b0;
          end else begin
            timeoutCnt_q <= timeoutCnt_q + 20'd1;
          end
        end

        ISSUE: begin
          timeoutCnt_q <= '0;
          if (bus.iRxDV) begin
            err_q     <= 1'b1;
            errCode_q <= ERR_OVERRUN;
          end
          if (bus.iCmdReady) begin
            cmdValid_q <= 1'b0;
            busy_q     <= 1'b0;
            state_q    <= IDLE;
          end
        end

        default: begin
          timeoutCnt_q <= '0;
          cmdValid_q   <= 1'b0;
          busy_q       <= 1'b0;
          state_q      <= IDLE;
        end
      endcase
    end
  end

  assign bus.oCmd      = cmd_q;
  assign bus.oArg      = arg_q;
  assign bus.oCmdValid = cmdValid_q;
  assign bus.oBusy     = busy_q;
  assign bus.oErr      = err_q;
  assign bus.oErrCode  = errCode_q;

endmodule

// File: doc/uart_cmd_ctrl.md
# uart_cmd_ctrl

Frame decoder and command sequencer between `uart_rx` and the command-execution logic. Consumes the received byte stream (`o_Rx_DV`/`o_Rx_Byte`), hunts for a sync byte, collects a 4-byte command frame, validates it, and presents one opcode plus argument to the downstream executor with a valid/ready handshake. It also enforces an inter-byte timeout and reports framing errors.

## Interface
- `SYNC_BYTE`, 8'hA5, frame start marker.
- `TIMEOUT_CLKS`, 50000, maximum idle clocks between bytes inside a frame. Legal range is 2..2^20-1.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `iRxDV`  in  1  one-cycle byte-valid strobe from `uart_rx`.
- `iRxByte`  in  8  received byte; qualified by `iRxDV`.
- `oCmd`  out  3  decoded opcode.
- `oArg`  out  8  command argument.
- `oCmdValid`  out  1  command available.
- `iCmdReady`  in  1  executor accepts the command.
- `oBusy`  out  1  high in every state except IDLE.
- `oErr`  out  1  one-cycle error pulse.
- `oErrCode`  out  2  error cause, valid while `oErr` is high:
  - 0 = checksum
  - 1 = bad opcode byte
  - 2 = timeout
  - 3 = overrun

## Operation
- Frame format is SYNC, CMD, ARG, CHK.
  - CMD[7:3] must be 0; `oCmd` = CMD[2:0].
  - CHK must equal (CMD + ARG) mod 256. The 8-bit sum wraps and has no carry.
- FSM states: IDLE, GET_CMD, GET_ARG, GET_CHK, ISSUE.
- IDLE:
  - On `iRxDV` with byte == `SYNC_BYTE`, go to GET_CMD.
  - Any other byte is discarded silently and raises no error.
- GET_CMD:
  - On a byte with [7:3] != 0, pulse `oErr` with code 1 and go to IDLE.
  - Otherwise latch the byte and go to GET_ARG.
- GET_ARG: latch the byte and go to GET_CHK.
- GET_CHK:
  - Checksum match: load `oCmd`/`oArg` and go to ISSUE.
  - Mismatch: pulse `oErr` with code 0 and go to IDLE.
- ISSUE:
  - `oCmdValid` is high.
  - When `oCmdValid && iCmdReady` at an edge, the transfer completes and the FSM goes to IDLE.
  - `iRxDV` in ISSUE, including the handshake cycle, drops the byte and pulses `oErr` with code 3. The FSM stays in ISSUE unless the handshake completes in that same cycle; the pending command is unaffected.
- Timeout counter (20 bits):
  - Clears on entry to GET_CMD and on each byte accepted in GET_*.
  - Increments every cycle in GET_* without `iRxDV`.
  - When it reaches `TIMEOUT_CLKS`-1, pulse `oErr` with code 2 and go to IDLE.
  - A byte arriving in the expiry cycle takes priority: it is consumed and no timeout fires.
  - The counter is held at 0 in IDLE and ISSUE. No timeout applies while waiting for `iCmdReady`.
- `oErr` priority: only one cause is possible per state, so no arbitration is needed. `oErrCode` holds its last value when `oErr` is low.
- Reset, at any time including mid-frame or mid-ISSUE:
  - State goes to IDLE and the pending command is discarded.
  - Reset values: `oCmd` = 0, `oArg` = 0, `oCmdValid` = 0, `oBusy` = 0, `oErr` = 0, `oErrCode` = 0, counter = 0.

## Timing
- All outputs are registered.
- CHK byte strobe at edge N: `oCmdValid` = 1 from N+1.
- Errors: a bad byte or a checksum mismatch at edge N produces `oErr` high for exactly cycle N+1.
- `oCmd`/`oArg` are stable while `oCmdValid` is high and hold their value after the transfer.
- Handshake at edge M: `oCmdValid` = 0 and `oBusy` = 0 from M+1. A SYNC byte strobed at M+1 is accepted.
- Minimum frame-to-command latency is 4 strobes plus 1 clock. The throughput limit is the UART byte rate.
- Timeout: the last accepted byte at edge N with no further strobes gives `oErr` (code 2) for exactly the cycle after edge N+`TIMEOUT_CLKS`-1.

## Test plan
- Clean frame A5,03,10,13 with `iCmdReady` tied high -> `oCmdValid` pulses 1 cycle with `oCmd`=3 and `oArg`=8'h10; `oErr` never asserts.
- Frame A5,07,FF,06 (wrapped sum) with `iCmdReady` low for 10 cycles -> `oCmdValid` held 10 cycles with outputs stable, transfer on ready, then IDLE.
- Bytes 00,5A,A5,08 -> the first two are ignored; 08 gives `oErr` code 1 and the FSM returns to IDLE. Then A5,01,01,03 -> `oErr` code 0 and no command issued.
- `TIMEOUT_CLKS`=8: A5,02 then silence -> `oErr` code 2 exactly 8 cycles after the 02 strobe. A second run with a strobe in the expiry cycle produces no timeout.
- Valid frame held in ISSUE (ready low), then byte 55 strobed -> `oErr` code 3; the command is still delivered unchanged when ready rises.
- `rst_n` asserted mid GET_ARG and again during ISSUE -> all outputs zero immediately. After release, a clean frame decodes normally.
